uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 9 +
 rtl/sync_fifo.sv | 35 +++
 rtl/uart_tx_fifo.sv | 76 +++++++
 tb/tb_uart_tx_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, 8N1 frame constants and baud divisor helper.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, full/empty flags and occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);
   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first, registered tx line.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 12_000_000,
   parameter int UART_BAUD = 9600,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                ICE_CLK,
   input  logic                RST,
   input  logic                wr_valid,
   input  logic [7:0]          wr_byte,
   output logic                wr_ready,
   output logic                tx,
   output logic                busy,
   output logic [DEPTH_LOG2:0] count
);
   localparam int CPB = clks_per_bit(CLK_HZ, UART_BAUD);
   localparam int BW = $clog2(CPB);
   localparam logic [BW-1:0] LAST_CLK = BW'(CPB - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   tx_state_t state;
   logic [BW-1:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] shifter, head;
   logic full, empty, pop, bit_end;
   assign bit_end = baud == LAST_CLK;
   // Popping from STOP's last cycle makes back-to-back frames gapless.
   assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
   assign wr_ready = !full;
   assign busy = (state != IDLE) || !empty;
   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk(ICE_CLK),
      .rst(RST),
      .push(wr_valid),
      .din(wr_byte),
      .pop(pop),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge ICE_CLK)
      if (RST) begin
         state <= IDLE;
         baud <= '0;
         bit_idx <= '0;
         shifter <= '0;
         tx <= 1'b1;
      end else if (pop) begin
         state <= START;
         shifter <= head;
         baud <= '0;
         tx <= 1'b0;
      end else if (state != IDLE) begin
         baud <= bit_end ? '0 : baud + 1'b1;
         case (state)
            START: if (bit_end) begin
               state <= DATA;
               bit_idx <= '0;
               tx <= shifter[0];
            end
            DATA: if (bit_end) begin
               shifter <= shifter >> 1;
               bit_idx <= bit_idx + 1'b1;
               state <= bit_idx == LAST_BIT ? STOP : DATA;
               tx <= bit_idx == LAST_BIT ? 1'b1 : shifter[1];
            end
            STOP: if (bit_end) begin
               state <= IDLE;
               tx <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random/directed stimulus checked each cycle against a queue-and-frame-timer reference model.
module tb_uart_tx_fifo;
   localparam int CPB = 16;
   localparam int FRAME = 10 * CPB;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_valid = 1'b0;
   logic [7:0] wr_byte = 8'h00;
   logic wr_ready, tx, busy;
   logic [4:0] count;
   int checks = 0;
   int errors = 0;
   logic [7:0] m_q[$];
   logic m_active = 1'b0;
   int m_el = 0;
   logic [7:0] m_cur = 8'h00;

   uart_tx_fifo #(.CLK_HZ(16), .UART_BAUD(1), .DEPTH_LOG2(4)) dut (
      .ICE_CLK(clk),
      .RST(rst),
      .wr_valid(wr_valid),
      .wr_byte(wr_byte),
      .wr_ready(wr_ready),
      .tx(tx),
      .busy(busy),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference: a frame is 160 cycles; line level is picked from elapsed/16.
   function automatic logic exp_tx();
      if (!m_active) return 1'b1;
      if (m_el < CPB) return 1'b0;
      if (m_el >= 9 * CPB) return 1'b1;
      return m_cur[m_el / CPB - 1];
   endfunction

   task automatic model(input logic v, input logic [7:0] b, input logic r);
      logic acc;
      if (r) begin
         m_q.delete();
         m_active = 1'b0;
         m_el = 0;
         return;
      end
      acc = v && (m_q.size() < DEPTH);
      if (!m_active || m_el == FRAME - 1) begin
         if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_active = 1'b1;
            m_el = 0;
         end else m_active = 1'b0;
      end else m_el++;
      if (acc) m_q.push_back(b);
   endtask

   task automatic cycle(input logic v, input logic [7:0] b, input logic r);
      rst = r;
      wr_valid = v;
      wr_byte = b;
      @(posedge clk);
      model(v, b, r);
      @(negedge clk);
      chk("tx", tx, exp_tx());
      chk("count", count, m_q.size());
      chk("busy", busy, m_active || m_q.size() > 0);
      chk("wr_ready", wr_ready, m_q.size() < DEPTH);
   endtask

   task automatic put(input logic [7:0] b);
      logic will;
      for (int k = 0; k < 2 * FRAME; k++) begin
         will = m_q.size() < DEPTH;
         cycle(1'b1, b, 1'b0);
         if (will) return;
      end
      chk("put_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < FRAME * (DEPTH + 3); k++) begin
         if (!m_active && m_q.size() == 0) return;
         cycle(1'b0, 8'h00, 1'b0);
      end
      chk("drain_timeout", 0, 1);
   endtask

   initial begin
      logic [7:0] d;
      logic will;
      int guard;
      repeat (3) cycle(1'b0, 8'h00, 1'b1);
      // single byte, exact line pattern and busy fall
      put(8'h55);
      drain();
      idle(5);
      // two contiguous frames
      put(8'hA3);
      put(8'h0F);
      drain();
      idle(3);
      // overfill at one byte per cycle
      for (int i = 0; i <= 16; i++) put(8'(i));
      drain();
      // hold valid while full: one accept per pop
      for (int i = 0; i < 20; i++) put(8'($urandom));
      d = 8'($urandom);
      for (int i = 0; i < 3 * FRAME + 20; i++) begin
         will = m_q.size() < DEPTH;
         cycle(1'b1, d, 1'b0);
         if (will) d = 8'($urandom);
      end
      drain();
      // reset mid-frame with bytes queued
      put(8'hC3);
      for (int i = 0; i < 3; i++) put(8'($urandom));
      guard = 0;
      while (!(m_active && m_cur == 8'hC3 && m_el == 49) && guard < 2 * FRAME) begin
         cycle(1'b0, 8'h00, 1'b0);
         guard++;
      end
      chk("rst_reach", guard < 2 * FRAME, 1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("rst_tx", tx, 1);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      idle(2 * FRAME);
      // rejected offer of 0x12 while full
      put(8'hFF);
      while (m_q.size() < DEPTH) put(8'($urandom));
      for (int i = 0; i < 30; i++) cycle(1'b1, 8'h12, 1'b0);
      drain();
      // random traffic
      for (int i = 0; i < 2500; i++) cycle($urandom_range(0, 30) == 0, 8'($urandom), 1'b0);
      drain();
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
